regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Shares the dual-read/single-write register-file RAM (ce/rr/select-port style, registered reads) between two requesters: requester 0 is the execute stage and requester 1 is the load/debug port.
- Clears the RAM after reset, then grants one operation per cycle with round-robin priority.
- Drives all RAM control, select and write-data pins.
- Returns read data to the granted requester one cycle after acceptance.

Parameters:
- MEM_WIDTH, 16, data width of a RAM word.
- ADD_LENGTH, 3, RAM address width.
- MEM_LENGTH, 8, number of RAM words to clear during init (≤ 2**ADD_LENGTH).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request N present (N = 0,1; the same set of ports exists for each).
- reqN_ready  out  1  request N accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read pair.
- reqN_rs1  in  ADD_LENGTH  read address 1.
- reqN_rs2  in  ADD_LENGTH  read address 2.
- reqN_wsel  in  ADD_LENGTH  write address.
- reqN_wdata  in  MEM_WIDTH  write data.
- rspN_valid  out  1  read data for N valid this cycle.
- rspN_data1  out  MEM_WIDTH  data at rs1.
- rspN_data2  out  MEM_WIDTH  data at rs2.
- ram_ce  out  1  RAM chip enable.
- ram_rr  out  1  RAM mode: 1 = write, 0 = read.
- ram_out_data_1_sel  out  ADD_LENGTH  RAM read select 1.
- ram_out_data_2_sel  out  ADD_LENGTH  RAM read select 2.
- ram_in_data_1_sel  out  ADD_LENGTH  RAM write select.
- ram_in_data_1  out  MEM_WIDTH  RAM write data.
- ram_out_data_1  in  MEM_WIDTH  RAM read data 1.
- ram_out_data_2  in  MEM_WIDTH  RAM read data 2.
- busy  out  1  high while clearing.

Behaviour:
- State machine with two states, INIT and RUN.
- On the cycle following rst=1:
  - state = INIT, init_cnt = 0, last_grant = 1 (so requester 0 wins first), rsp pipeline cleared.
  - All reqN_ready = 0, rspN_valid = 0, busy = 1.
- INIT: each cycle drives ram_ce=1, ram_rr=1, ram_in_data_1_sel=init_cnt, ram_in_data_1=0, then increments init_cnt.
  - When init_cnt == MEM_LENGTH-1 is written, the next state is RUN and busy = 0.
  - Init therefore takes exactly MEM_LENGTH cycles.
- RUN: grant is combinational from the valids.
  - Only one valid: that requester is granted.
  - Both valid: the requester whose index differs from last_grant is granted.
  - reqN_ready = grant N. Accept = valid & ready in the same cycle.
  - last_grant updates to N on each accept.
  - The loser sees ready=0 and must hold its request stable.
- Granted write: in the accept cycle drive ram_ce=1, ram_rr=1, ram_in_data_1_sel=wsel, ram_in_data_1=wdata. The RAM commits on that edge. No response is returned.
- Granted read: in the accept cycle drive ram_ce=1, ram_rr=0, read sels=rs1/rs2.
  - Next cycle: rspN_valid=1 and rspN_data1/2 = ram_out_data_1/2 (combinational pass-through).
  - Latency is 1 cycle. Back-to-back reads are allowed at 1 op per cycle.
- No grant: ram_ce=0, ram_rr=0. All selects and write data are driven to 0. These are never high-Z.
- rspN_data outputs are 0 whenever rspN_valid=0.
- Read after write:
  - A write accepted in cycle t is visible to a read accepted in cycle t+1 or later.
  - A same-cycle read and write is impossible because there is a single grant.
- Responses cannot be back-pressured; the requester must sink them.
- rst in any state aborts everything: a pending response is dropped (rspN_valid=0 next cycle) and INIT restarts from address 0.
- Requests arriving during INIT stall with ready=0.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_grant0, stat_grant1 and stat_conflict, each 16 bits and saturating at 16'hFFFF.
  - The grant counters count accepts per requester. stat_conflict counts RUN cycles in which both valids are high.
  - All three clear on rst.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package regfile_arb_pkg holds:
  - State encoding: ST_INIT = 1'b0, ST_RUN = 1'b1.
  - RAM mode constants: RR_READ = 0, RR_WRITE = 1.
  - Default width constants.
- One natural sub-module, rr_arb2: a 2-input round-robin arbiter containing the last_grant register, with inputs valid[1:0] and advance, and one-hot grant[1:0] as output.

Test Plan:
- Reset then idle:
  - busy=1 for exactly 8 cycles with ram_in_data_1_sel stepping 0..7 and data 0, then busy=0.
  - Afterwards, a read of rs1=3, rs2=7 returns 0, 0.
- Write then read: req0 writes wsel=5, wdata=16'hBEEF. Next cycle req1 reads rs1=5, rs2=0 → rsp1_valid one cycle later with data1=16'hBEEF, data2=0.
- Contention: both valid for 4 cycles, each issuing reads → grants alternate 0,1,0,1. Each rsp arrives 1 cycle after its own accept, and the loser holds its request.
- Back-to-back: req0 reads addresses 1,2,3 on consecutive cycles after writes of 16'h11/16'h22/16'h33 → rsp0_valid high for 3 consecutive cycles with 16'h11, 16'h22, 16'h33.
- Reset mid-op: a read is accepted, then rst=1 is asserted in the response cycle → rsp0_valid=0 the cycle after rst, INIT restarts at address 0, and previously written data reads back 0.
- With REGFILE_ARB_STATS_EN: the contention scenario yields stat_grant0=2, stat_grant1=2, stat_conflict=4.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
// Holds the FSM state encoding, RAM mode constants and default widths.
package regfile_arb_pkg;

  localparam int DEF_MEM_WIDTH  = 16;
  localparam int DEF_ADD_LENGTH = 3;
  localparam int DEF_MEM_LENGTH = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic RR_READ  = 1'b0;
  localparam logic RR_WRITE = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with one-hot grant.
// last_grant resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (advance) last_grant <= grant[1];
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares a dual-read/single-write register-file RAM between two requesters.
// Optional macro REGFILE_ARB_STATS_EN adds saturating grant/conflict counters.
//
// state   | meaning
// ST_INIT | clearing RAM words 0..MEM_LENGTH-1, requests stalled, busy=1
// ST_RUN  | one round-robin grant per cycle, reads answered next cycle
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int ADD_LENGTH = DEF_ADD_LENGTH,
  parameter int MEM_LENGTH = DEF_MEM_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADD_LENGTH-1:0] req0_rs1,
  input  logic [ADD_LENGTH-1:0] req0_rs2,
  input  logic [ADD_LENGTH-1:0] req0_wsel,
  input  logic [MEM_WIDTH-1:0]  req0_wdata,
  output logic                  rsp0_valid,
  output logic [MEM_WIDTH-1:0]  rsp0_data1,
  output logic [MEM_WIDTH-1:0]  rsp0_data2,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADD_LENGTH-1:0] req1_rs1,
  input  logic [ADD_LENGTH-1:0] req1_rs2,
  input  logic [ADD_LENGTH-1:0] req1_wsel,
  input  logic [MEM_WIDTH-1:0]  req1_wdata,
  output logic                  rsp1_valid,
  output logic [MEM_WIDTH-1:0]  rsp1_data1,
  output logic [MEM_WIDTH-1:0]  rsp1_data2,
  output logic                  ram_ce,
  output logic                  ram_rr,
  output logic [ADD_LENGTH-1:0] ram_out_data_1_sel,
  output logic [ADD_LENGTH-1:0] ram_out_data_2_sel,
  output logic [ADD_LENGTH-1:0] ram_in_data_1_sel,
  output logic [MEM_WIDTH-1:0]  ram_in_data_1,
  input  logic [MEM_WIDTH-1:0]  ram_out_data_1,
  input  logic [MEM_WIDTH-1:0]  ram_out_data_2,
`ifdef REGFILE_ARB_STATS_EN
  output logic [15:0]           stat_grant0,
  output logic [15:0]           stat_grant1,
  output logic [15:0]           stat_conflict,
`endif
  output logic                  busy
);

  state_t                state, next_state;
  logic [ADD_LENGTH-1:0] init_cnt;
  logic [1:0]            rsp_pend;
  logic [1:0]            run_valid;
  logic [1:0]            grant;
  logic                  accept;
  logic                  g_we;
  logic [ADD_LENGTH-1:0] g_rs1, g_rs2, g_wsel;
  logic [MEM_WIDTH-1:0]  g_wdata;

  // Requests are masked during INIT so they stall with ready=0.
  assign run_valid = {req1_valid, req0_valid} & {2{state == ST_RUN}};
  assign accept    = |grant;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (run_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign busy       = (state == ST_INIT);

  assign g_we    = grant[1] ? req1_we    : req0_we;
  assign g_rs1   = grant[1] ? req1_rs1   : req0_rs1;
  assign g_rs2   = grant[1] ? req1_rs2   : req0_rs2;
  assign g_wsel  = grant[1] ? req1_wsel  : req0_wsel;
  assign g_wdata = grant[1] ? req1_wdata : req0_wdata;

  always_comb begin
    next_state         = state;
    ram_ce             = 1'b0;
    ram_rr             = RR_READ;
    ram_out_data_1_sel = '0;
    ram_out_data_2_sel = '0;
    ram_in_data_1_sel  = '0;
    ram_in_data_1      = '0;
    case (state)
      ST_INIT: begin
        ram_ce            = 1'b1;
        ram_rr            = RR_WRITE;
        ram_in_data_1_sel = init_cnt;
        if (init_cnt == ADD_LENGTH'(MEM_LENGTH - 1)) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          ram_ce = 1'b1;
          if (g_we) begin
            ram_rr            = RR_WRITE;
            ram_in_data_1_sel = g_wsel;
            ram_in_data_1     = g_wdata;
          end else begin
            ram_out_data_1_sel = g_rs1;
            ram_out_data_2_sel = g_rs2;
          end
        end
      end
      default: next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      rsp_pend <= 2'b00;
    end else begin
      state    <= next_state;
      init_cnt <= (state == ST_INIT && next_state == ST_INIT) ? init_cnt + 1'b1 : '0;
      rsp_pend <= {grant[1] & ~req1_we, grant[0] & ~req0_we};
    end
  end

  // Registered RAM reads land the cycle after accept; pass them straight through.
  assign rsp0_valid = rsp_pend[0];
  assign rsp1_valid = rsp_pend[1];
  assign rsp0_data1 = rsp_pend[0] ? ram_out_data_1 : '0;
  assign rsp0_data2 = rsp_pend[0] ? ram_out_data_2 : '0;
  assign rsp1_data1 = rsp_pend[1] ? ram_out_data_1 : '0;
  assign rsp1_data2 = rsp_pend[1] ? ram_out_data_2 : '0;

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant[0]) stat_grant0 <= sat_inc16(stat_grant0);
      if (grant[1]) stat_grant1 <= sat_inc16(stat_grant1);
      if (run_valid == 2'b11) stat_conflict <= sat_inc16(stat_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural registered-read RAM,
// a shadow memory and a response scoreboard queue.
module tb_regfile_arbiter;
  import regfile_arb_pkg::*;

  localparam int W = 16;
  localparam int A = 3;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
  logic [A-1:0] req0_rs1, req0_rs2, req0_wsel, req1_rs1, req1_rs2, req1_wsel;
  logic [W-1:0] req0_wdata, req1_wdata;
  logic rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_data1, rsp0_data2, rsp1_data1, rsp1_data2;
  logic ram_ce, ram_rr;
  logic [A-1:0] ram_out_data_1_sel, ram_out_data_2_sel, ram_in_data_1_sel;
  logic [W-1:0] ram_in_data_1, ram_out_data_1, ram_out_data_2;
  logic busy;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_wsel(req0_wsel), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_data1(rsp0_data1), .rsp0_data2(rsp0_data2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_wsel(req1_wsel), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_data1(rsp1_data1), .rsp1_data2(rsp1_data2),
    .ram_ce(ram_ce), .ram_rr(ram_rr),
    .ram_out_data_1_sel(ram_out_data_1_sel), .ram_out_data_2_sel(ram_out_data_2_sel),
    .ram_in_data_1_sel(ram_in_data_1_sel), .ram_in_data_1(ram_in_data_1),
    .ram_out_data_1(ram_out_data_1), .ram_out_data_2(ram_out_data_2),
`ifdef REGFILE_ARB_STATS_EN
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict),
`endif
    .busy(busy)
  );

  // Registered-read RAM; starts with random contents so the clear is observable.
  logic [W-1:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
    ram_out_data_1 = '0;
    ram_out_data_2 = '0;
  end
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_rr) mem[ram_in_data_1_sel] <= ram_in_data_1;
      else begin
        ram_out_data_1 <= mem[ram_out_data_1_sel];
        ram_out_data_2 <= mem[ram_out_data_2_sel];
      end
    end
  end

  typedef struct {
    int           req;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
  } rsp_t;

  rsp_t         exp_q[$];
  logic [W-1:0] shadow [8];
  int           checks = 0;
  int           errors = 0;
  int           init_idx = 0;
  int           exp_g0 = 0, exp_g1 = 0, exp_conf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    exp_q.delete();
    init_idx = 0;
    exp_g0 = 0; exp_g1 = 0; exp_conf = 0;
  endtask

  // One cycle: sample at negedge, update model, then advance to posedge+1.
  task automatic tick(input logic eg0, input logic eg1, input logic ebusy);
    rsp_t e;
    logic ev0, ev1, we;
    logic [W-1:0] e01, e02, e11, e12, wd;
    logic [A-1:0] r1, r2, ws;
    @(negedge clk);
    ev0 = 1'b0; ev1 = 1'b0; e01 = '0; e02 = '0; e11 = '0; e12 = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.req == 0) begin ev0 = 1'b1; e01 = e.d1; e02 = e.d2; end
      else begin ev1 = 1'b1; e11 = e.d1; e12 = e.d2; end
    end
    chk("rsp0_valid", rsp0_valid, ev0);
    chk("rsp0_data1", rsp0_data1, e01);
    chk("rsp0_data2", rsp0_data2, e02);
    chk("rsp1_valid", rsp1_valid, ev1);
    chk("rsp1_data1", rsp1_data1, e11);
    chk("rsp1_data2", rsp1_data2, e12);
    chk("busy", busy, ebusy);
    chk("req0_ready", req0_ready, eg0);
    chk("req1_ready", req1_ready, eg1);
`ifdef REGFILE_ARB_STATS_EN
    chk("stat_grant0", stat_grant0, exp_g0);
    chk("stat_grant1", stat_grant1, exp_g1);
    chk("stat_conflict", stat_conflict, exp_conf);
`endif
    if (ebusy) begin
      chk("init_ce", ram_ce, 1'b1);
      chk("init_rr", ram_rr, RR_WRITE);
      chk("init_sel", ram_in_data_1_sel, init_idx[A-1:0]);
      chk("init_data", ram_in_data_1, '0);
      init_idx++;
    end else begin
      if (req0_valid && req1_valid) exp_conf++;
      if (eg0 || eg1) begin
        we = eg1 ? req1_we : req0_we;
        r1 = eg1 ? req1_rs1 : req0_rs1;
        r2 = eg1 ? req1_rs2 : req0_rs2;
        ws = eg1 ? req1_wsel : req0_wsel;
        wd = eg1 ? req1_wdata : req0_wdata;
        if (eg1) exp_g1++; else exp_g0++;
        chk("grant_ce", ram_ce, 1'b1);
        chk("grant_rr", ram_rr, we);
        if (we) begin
          chk("wr_sel", ram_in_data_1_sel, ws);
          chk("wr_data", ram_in_data_1, wd);
          shadow[ws] = wd;
        end else begin
          chk("rd_sel1", ram_out_data_1_sel, r1);
          chk("rd_sel2", ram_out_data_2_sel, r2);
          e.req = eg1 ? 1 : 0;
          e.d1  = shadow[r1];
          e.d2  = shadow[r2];
          exp_q.push_back(e);
        end
      end else begin
        chk("idle_ce", ram_ce, 1'b0);
        chk("idle_rr", ram_rr, 1'b0);
        chk("idle_sels", {ram_out_data_1_sel, ram_out_data_2_sel, ram_in_data_1_sel}, '0);
        chk("idle_wdata", ram_in_data_1, '0);
      end
    end
    if (rst) clear_model();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int n, input logic [A-1:0] a1, input logic [A-1:0] a2);
    if (n == 0) begin req0_valid = 1'b1; req0_we = 1'b0; req0_rs1 = a1; req0_rs2 = a2; end
    else begin req1_valid = 1'b1; req1_we = 1'b0; req1_rs1 = a1; req1_rs2 = a2; end
  endtask

  task automatic set_wr(input int n, input logic [A-1:0] ws, input logic [W-1:0] wd);
    if (n == 0) begin req0_valid = 1'b1; req0_we = 1'b1; req0_wsel = ws; req0_wdata = wd; end
    else begin req1_valid = 1'b1; req1_we = 1'b1; req1_wsel = ws; req1_wdata = wd; end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_rs1 = '0; req0_rs2 = '0; req0_wsel = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_rs1 = '0; req1_rs2 = '0; req1_wsel = '0; req1_wdata = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Init sweep with a read held pending; it must stall until RUN.
    set_rd(0, 3'd3, 3'd7);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);

    // Write then read from the other requester.
    set_wr(0, 3'd5, 16'hBEEF);
    tick(1'b1, 1'b0, 1'b0);
    req0_valid = 1'b0;
    set_rd(1, 3'd5, 3'd0);
    tick(1'b0, 1'b1, 1'b0);
    req1_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // Contention: last grant was 1, so 0 wins first; loser holds its request.
    set_rd(0, 3'd5, 3'd0);
    set_rd(1, 3'd2, 3'd3);
    tick(1'b1, 1'b0, 1'b0);
    set_rd(0, 3'd1, 3'd5);
    tick(1'b0, 1'b1, 1'b0);
    set_rd(1, 3'd5, 3'd5);
    tick(1'b1, 1'b0, 1'b0);
    set_rd(0, 3'd7, 3'd7);
    tick(1'b0, 1'b1, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // Back-to-back writes then reads from requester 0.
    set_wr(0, 3'd1, 16'h0011);
    tick(1'b1, 1'b0, 1'b0);
    set_wr(0, 3'd2, 16'h0022);
    tick(1'b1, 1'b0, 1'b0);
    set_wr(0, 3'd3, 16'h0033);
    tick(1'b1, 1'b0, 1'b0);
    set_rd(0, 3'd1, 3'd2);
    tick(1'b1, 1'b0, 1'b0);
    set_rd(0, 3'd2, 3'd3);
    tick(1'b1, 1'b0, 1'b0);
    set_rd(0, 3'd3, 3'd1);
    tick(1'b1, 1'b0, 1'b0);
    req0_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // Reset in the response cycle of an accepted read.
    set_rd(0, 3'd5, 3'd1);
    tick(1'b1, 1'b0, 1'b0);
    req0_valid = 1'b0;
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
    set_rd(0, 3'd5, 3'd1);
    tick(1'b1, 1'b0, 1'b0);
    req0_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
